// File: rtl/mem_arbiter_if.sv
// Request/completion bundle between the three memory requesters, MemCtrl and mem_arbiter.
// The arbiter uses the master view; requesters and MemCtrl use the slave view.
interface mem_arbiter_if #(
   parameter int DATA_W = 32
);
   logic              ic_valid;
   logic [DATA_W-1:0] ic_addr;
   logic              ic_enable;
   logic [DATA_W-1:0] ic_inst;

   logic              pf_valid;
   logic [DATA_W-1:0] pf_addr;
   logic              pf_enable;
   logic [DATA_W-1:0] pf_data;

   logic              lsb_valid;
   logic [DATA_W-1:0] lsb_addr;
   logic [DATA_W-1:0] lsb_wdata;
   logic [2:0]        lsb_size;
   logic              lsb_wr_tag;
   logic              lsb_enable;
   logic [DATA_W-1:0] lsb_rdata;

   logic              mem_valid;
   logic [DATA_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [2:0]        mem_size;
   logic              mem_wr_tag;
   logic              mem_done;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      input  ic_valid, ic_addr,
      input  pf_valid, pf_addr,
      input  lsb_valid, lsb_addr, lsb_wdata, lsb_size, lsb_wr_tag,
      input  mem_done, mem_rdata,
      output ic_enable, ic_inst,
      output pf_enable, pf_data,
      output lsb_enable, lsb_rdata,
      output mem_valid, mem_addr, mem_wdata, mem_size, mem_wr_tag
   );

   modport slave (
      output ic_valid, ic_addr,
      output pf_valid, pf_addr,
      output lsb_valid, lsb_addr, lsb_wdata, lsb_size, lsb_wr_tag,
      output mem_done, mem_rdata,
      input  ic_enable, ic_inst,
      input  pf_enable, pf_data,
      input  lsb_enable, lsb_rdata,
      input  mem_valid, mem_addr, mem_wdata, mem_size, mem_wr_tag
   );
endinterface

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing the MemCtrl port between ICache, LSB and prefetcher,
// with mispredict draining of speculative requests and ICache anti-starvation.
module mem_arbiter #(
   parameter int STARVE_LIMIT = 8,
   parameter int CNT_W        = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rdy,
   input  logic          jump_flag,
   mem_arbiter_if.master bus
);
   typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_IC, OWN_PF, OWN_LSB} owner_t;

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   state_t           state;
   owner_t           owner;
   logic [CNT_W-1:0] starve_cnt;
   owner_t           winner;
   logic             starved;
   logic             drainable;

   assign starved   = (starve_cnt >= LIMIT);
   // A store already issued to MemCtrl is architectural and must complete.
   assign drainable = (owner != OWN_LSB) || !bus.mem_wr_tag;

   // Requesters deassert valid in the cycle their enable is high, so every
   // valid seen here is a fresh request. A flush only lets a store through.
   always_comb begin
      winner = OWN_NONE;
      if (bus.lsb_valid && bus.lsb_wr_tag) begin
         winner = OWN_LSB;
      end else if (!jump_flag) begin
         if (bus.ic_valid && starved)  winner = OWN_IC;
         else if (bus.lsb_valid)       winner = OWN_LSB;
         else if (bus.ic_valid)        winner = OWN_IC;
         else if (bus.pf_valid)        winner = OWN_PF;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         owner          <= OWN_NONE;
         starve_cnt     <= '0;
         bus.mem_valid  <= 1'b0;
         bus.mem_addr   <= '0;
         bus.mem_wdata  <= '0;
         bus.mem_size   <= '0;
         bus.mem_wr_tag <= 1'b0;
         bus.ic_enable  <= 1'b0;
         bus.ic_inst    <= '0;
         bus.pf_enable  <= 1'b0;
         bus.pf_data    <= '0;
         bus.lsb_enable <= 1'b0;
         bus.lsb_rdata  <= '0;
      end else if (rdy) begin
         bus.ic_enable  <= 1'b0;
         bus.pf_enable  <= 1'b0;
         bus.lsb_enable <= 1'b0;

         if (jump_flag || (state == IDLE && winner == OWN_IC)) begin
            starve_cnt <= '0;
         end else if (bus.ic_valid && owner != OWN_IC && !starved) begin
            starve_cnt <= starve_cnt + 1'b1;
         end

         case (state)
            IDLE: begin
               if (winner != OWN_NONE) begin
                  state         <= BUSY;
                  owner         <= winner;
                  bus.mem_valid <= 1'b1;
                  if (winner == OWN_LSB) begin
                     bus.mem_addr   <= bus.lsb_addr;
                     bus.mem_wdata  <= bus.lsb_wdata;
                     bus.mem_size   <= bus.lsb_size;
                     bus.mem_wr_tag <= bus.lsb_wr_tag;
                  end else begin
                     bus.mem_addr   <= (winner == OWN_IC) ? bus.ic_addr : bus.pf_addr;
                     bus.mem_wdata  <= '0;
                     bus.mem_size   <= 3'd4;
                     bus.mem_wr_tag <= 1'b0;
                  end
               end
            end
            BUSY: begin
               if (bus.mem_done) begin
                  state         <= IDLE;
                  owner         <= OWN_NONE;
                  bus.mem_valid <= 1'b0;
                  // A flush landing on the completion cycle still discards speculative data.
                  if (!(jump_flag && drainable)) begin
                     case (owner)
                        OWN_IC: begin
                           bus.ic_enable <= 1'b1;
                           bus.ic_inst   <= bus.mem_rdata;
                        end
                        OWN_PF: begin
                           bus.pf_enable <= 1'b1;
                           bus.pf_data   <= bus.mem_rdata;
                        end
                        OWN_LSB: begin
                           bus.lsb_enable <= 1'b1;
                           bus.lsb_rdata  <= bus.mem_rdata;
                        end
                        default: ;
                     endcase
                  end
               end else if (jump_flag && drainable) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (bus.mem_done) begin
                  state         <= IDLE;
                  owner         <= OWN_NONE;
                  bus.mem_valid <= 1'b0;
               end
            end
            default: begin
               state         <= IDLE;
               owner         <= OWN_NONE;
               bus.mem_valid <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table with a grant/completion scoreboard,
// plus hand-written flush, starvation, freeze and reset sequences.
module tb_mem_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rdy = 1'b1;
   logic jump_flag = 1'b0;

   mem_arbiter_if bus ();

   mem_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .rdy       (rdy),
      .jump_flag (jump_flag),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   localparam logic [1:0] W_NONE = 2'd0, W_IC = 2'd1, W_PF = 2'd2, W_LSB = 2'd3;

   typedef struct {
      logic [1:0]  who;
      logic [31:0] addr;
      logic [2:0]  size;
      logic        wr;
      logic [31:0] wdata;
   } grant_t;

   typedef struct {
      logic [1:0]  who;
      logic [31:0] data;
   } done_t;

   typedef struct {
      logic        ic, pf, lsb, st;
      logic [2:0]  sz;
      logic [31:0] ic_a, pf_a, lsb_a, wd;
      int          lat;
      logic [1:0]  o0, o1, o2;
   } vec_t;

   grant_t      gq[$];
   done_t       dq[$];
   vec_t        vt[7];
   logic [31:0] rd_next;
   int          total = 0;
   int          bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_mem_valid"},  32'(bus.mem_valid),  0);
      chk({tag, "_mem_addr"},   bus.mem_addr,        0);
      chk({tag, "_mem_wdata"},  bus.mem_wdata,       0);
      chk({tag, "_mem_size"},   32'(bus.mem_size),   0);
      chk({tag, "_mem_wr_tag"}, 32'(bus.mem_wr_tag), 0);
      chk({tag, "_enables"},    32'({bus.ic_enable, bus.pf_enable, bus.lsb_enable}), 0);
      chk({tag, "_ic_inst"},    bus.ic_inst,   0);
      chk({tag, "_pf_data"},    bus.pf_data,   0);
      chk({tag, "_lsb_rdata"},  bus.lsb_rdata, 0);
   endtask

   function automatic vec_t mk(input logic ic, input logic pf, input logic lsb, input logic st,
                               input logic [2:0] sz, input logic [31:0] ic_a, input logic [31:0] pf_a,
                               input logic [31:0] lsb_a, input logic [31:0] wd, input int lat,
                               input logic [1:0] o0, input logic [1:0] o1, input logic [1:0] o2);
      vec_t v;
      v.ic = ic; v.pf = pf; v.lsb = lsb; v.st = st; v.sz = sz;
      v.ic_a = ic_a; v.pf_a = pf_a; v.lsb_a = lsb_a; v.wd = wd; v.lat = lat;
      v.o0 = o0; v.o1 = o1; v.o2 = o2;
      return v;
   endfunction

   task automatic push_grant(input logic [1:0] who, input vec_t v);
      grant_t g;
      g.who   = who;
      g.addr  = (who == W_IC) ? v.ic_a : (who == W_PF) ? v.pf_a : v.lsb_a;
      g.size  = (who == W_LSB) ? v.sz : 3'd4;
      g.wr    = (who == W_LSB) ? v.st : 1'b0;
      g.wdata = v.wd;
      if (who != W_NONE) gq.push_back(g);
   endtask

   // Plays MemCtrl and the requesters until all expected grants and completions are consumed.
   task automatic serve(input int lat, input int budget);
      int          left = 0;
      bit          busy = 1'b0;
      bit          ok = 1'b0;
      grant_t      cur;
      logic [1:0]  who;
      logic [31:0] dat;
      cur = '{W_NONE, 32'h0, 3'd0, 1'b0, 32'h0};
      for (int c = 0; c < budget && !ok; c++) begin
         @(negedge clk);
         bus.mem_done = 1'b0;
         if (bus.ic_enable || bus.pf_enable || bus.lsb_enable) begin
            who = bus.ic_enable ? W_IC : bus.pf_enable ? W_PF : W_LSB;
            dat = bus.ic_enable ? bus.ic_inst : bus.pf_enable ? bus.pf_data : bus.lsb_rdata;
            chk("one_enable", 32'(bus.ic_enable) + 32'(bus.pf_enable) + 32'(bus.lsb_enable), 1);
            chk("gap_after_done", 32'(bus.mem_valid), 0);
            if (dq.size() == 0) begin
               chk("spurious_enable", 32'(who), 0);
            end else begin
               done_t e;
               e = dq.pop_front();
               chk("enable_owner", 32'(who), 32'(e.who));
               chk("enable_data", dat, e.data);
            end
            if (who == W_IC) bus.ic_valid = 1'b0;
            if (who == W_PF) bus.pf_valid = 1'b0;
            if (who == W_LSB) bus.lsb_valid = 1'b0;
         end
         if (busy) begin
            chk("mem_valid_held", 32'(bus.mem_valid), 1);
            chk("mem_addr_stable", bus.mem_addr, cur.addr);
            left--;
            if (left == 0) begin
               bus.mem_done  = 1'b1;
               bus.mem_rdata = rd_next;
               dq.push_back('{cur.who, rd_next});
               rd_next = rd_next + 32'd1;
               busy = 1'b0;
            end
         end else if (bus.mem_valid) begin
            if (gq.size() == 0) begin
               chk("spurious_grant", bus.mem_addr, 0);
            end else begin
               cur = gq.pop_front();
               chk("grant_addr", bus.mem_addr, cur.addr);
               chk("grant_size", 32'(bus.mem_size), 32'(cur.size));
               chk("grant_wr_tag", 32'(bus.mem_wr_tag), 32'(cur.wr));
               if (cur.wr) chk("grant_wdata", bus.mem_wdata, cur.wdata);
               busy = 1'b1;
               left = lat;
            end
         end
         ok = !busy && !bus.mem_done && gq.size() == 0 && dq.size() == 0 &&
              !bus.ic_valid && !bus.pf_valid && !bus.lsb_valid;
      end
      chk("serve_complete", 32'(ok), 1);
   endtask

   task automatic wait_grant(input string name, input logic [31:0] addr);
      bit seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         seen = bus.mem_valid;
      end
      chk({name, "_grant"}, 32'(seen), 1);
      chk({name, "_addr"}, bus.mem_addr, addr);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  loads;
      int  left;
      bit  busy;
      bit  ic_done;

      bus.ic_valid = 0; bus.ic_addr = 0; bus.pf_valid = 0; bus.pf_addr = 0;
      bus.lsb_valid = 0; bus.lsb_addr = 0; bus.lsb_wdata = 0; bus.lsb_size = 0;
      bus.lsb_wr_tag = 0; bus.mem_done = 0; bus.mem_rdata = 0;

      #3 rst = 1'b0;
      #1 chk_zero("reset");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      //         ic pf lsb st sz    ic_a       pf_a       lsb_a         wd            lat order
      vt[0] = mk(1, 0, 0, 0, 3'd4, 32'h100, 32'h0,   32'h0,      32'h0,        4, W_IC,  W_NONE, W_NONE);
      vt[1] = mk(1, 1, 1, 1, 3'd1, 32'h200, 32'h204, 32'h30000,  32'h41,       2, W_LSB, W_IC,   W_PF);
      vt[2] = mk(1, 0, 1, 0, 3'd4, 32'h300, 32'h0,   32'h1000,   32'h0,        3, W_LSB, W_IC,   W_NONE);
      vt[3] = mk(0, 1, 0, 0, 3'd4, 32'h0,   32'h400, 32'h0,      32'h0,        1, W_PF,  W_NONE, W_NONE);
      vt[4] = mk(0, 1, 1, 0, 3'd2, 32'h0,   32'h404, 32'h1004,   32'h0,        2, W_LSB, W_PF,   W_NONE);
      vt[5] = mk(1, 1, 0, 0, 3'd4, 32'h308, 32'h408, 32'h0,      32'h0,        2, W_IC,  W_PF,   W_NONE);
      vt[6] = mk(0, 1, 1, 1, 3'd4, 32'h0,   32'h40c, 32'h2000,   32'h12345678, 3, W_LSB, W_PF,   W_NONE);

      rd_next = 32'hDEADBEEF;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         push_grant(vt[i].o0, vt[i]);
         push_grant(vt[i].o1, vt[i]);
         push_grant(vt[i].o2, vt[i]);
         bus.ic_valid = vt[i].ic;   bus.ic_addr = vt[i].ic_a;
         bus.pf_valid = vt[i].pf;   bus.pf_addr = vt[i].pf_a;
         bus.lsb_valid = vt[i].lsb; bus.lsb_addr = vt[i].lsb_a;
         bus.lsb_wr_tag = vt[i].st; bus.lsb_size = vt[i].sz; bus.lsb_wdata = vt[i].wd;
         serve(vt[i].lat, 200);
      end

      // Starvation: loads of latency 2 take 4 cycles each, so the counter reaches 8 after two loads.
      @(negedge clk); jump_flag = 1'b1;
      @(negedge clk); jump_flag = 1'b0;
      bus.ic_valid = 1; bus.ic_addr = 32'h500;
      bus.lsb_valid = 1; bus.lsb_wr_tag = 0; bus.lsb_size = 3'd4; bus.lsb_addr = 32'h3000;
      loads = 0; left = 0; busy = 0; ic_done = 0;
      for (int c = 0; c < 120 && !ic_done; c++) begin
         @(negedge clk);
         bus.mem_done = 1'b0;
         if (bus.lsb_enable) bus.lsb_addr = bus.lsb_addr + 32'd4;
         if (bus.ic_enable) begin
            ic_done = 1'b1;
            bus.ic_valid = 1'b0;
            chk("starve_ic_inst", bus.ic_inst, 32'h5AA50000);
         end
         if (busy) begin
            left--;
            if (left == 0) begin
               bus.mem_done = 1'b1;
               bus.mem_rdata = 32'h5AA50000;
               busy = 1'b0;
            end
         end else if (bus.mem_valid) begin
            if (bus.mem_addr == 32'h500) begin
               chk("starve_loads_before_ic", 32'(loads), 2);
               bus.lsb_valid = 1'b0;
            end else begin
               loads++;
            end
            busy = 1'b1;
            left = 2;
         end
      end
      chk("starve_ic_done", 32'(ic_done), 1);
      bus.ic_valid = 1'b0;
      bus.lsb_valid = 1'b0;

      // Flush while ICache owns the port: drain, no completion, back to IDLE.
      @(negedge clk);
      bus.ic_valid = 1; bus.ic_addr = 32'h600;
      wait_grant("flush_busy", 32'h600);
      @(negedge clk); jump_flag = 1'b1; bus.ic_valid = 1'b0;
      @(negedge clk); jump_flag = 1'b0;
      chk("drain_valid_1", 32'(bus.mem_valid), 1);
      @(negedge clk);
      chk("drain_valid_2", 32'(bus.mem_valid), 1);
      chk("drain_addr", bus.mem_addr, 32'h600);
      @(negedge clk); bus.mem_done = 1'b1; bus.mem_rdata = 32'h0BAD0BAD;
      @(negedge clk); bus.mem_done = 1'b0;
      chk("drain_no_enable", 32'(bus.ic_enable), 0);
      chk("drain_released", 32'(bus.mem_valid), 0);
      @(negedge clk);
      chk("drain_no_enable_late", 32'(bus.ic_enable), 0);
      rd_next = 32'h77770000;
      gq.push_back('{W_PF, 32'h610, 3'd4, 1'b0, 32'h0});
      bus.pf_valid = 1; bus.pf_addr = 32'h610;
      serve(2, 50);

      // Flush in the arbitration cycle: fetch/prefetch suppressed, then granted afterwards.
      @(negedge clk);
      jump_flag = 1'b1;
      bus.ic_valid = 1; bus.ic_addr = 32'h700; bus.pf_valid = 1; bus.pf_addr = 32'h704;
      @(negedge clk); jump_flag = 1'b0;
      chk("idle_flush_suppress", 32'(bus.mem_valid), 0);
      gq.push_back('{W_IC, 32'h700, 3'd4, 1'b0, 32'h0});
      gq.push_back('{W_PF, 32'h704, 3'd4, 1'b0, 32'h0});
      serve(2, 100);

      // A store still wins in a flush cycle.
      @(negedge clk);
      jump_flag = 1'b1;
      bus.lsb_valid = 1; bus.lsb_wr_tag = 1; bus.lsb_addr = 32'h3100; bus.lsb_wdata = 32'h77; bus.lsb_size = 3'd2;
      bus.ic_valid = 1; bus.ic_addr = 32'h708;
      @(negedge clk); jump_flag = 1'b0;
      chk("idle_flush_store_grant", 32'(bus.mem_valid), 1);
      chk("idle_flush_store_wr", 32'(bus.mem_wr_tag), 1);
      gq.push_back('{W_LSB, 32'h3100, 3'd2, 1'b1, 32'h77});
      gq.push_back('{W_IC, 32'h708, 3'd4, 1'b0, 32'h0});
      serve(2, 100);

      // Store in BUSY is not drained by a flush.
      @(negedge clk);
      bus.lsb_valid = 1; bus.lsb_wr_tag = 1; bus.lsb_addr = 32'h3200; bus.lsb_wdata = 32'hAB; bus.lsb_size = 3'd4;
      wait_grant("store_flush", 32'h3200);
      @(negedge clk); jump_flag = 1'b1;
      @(negedge clk); jump_flag = 1'b0; bus.mem_done = 1'b1; bus.mem_rdata = 32'h11;
      @(negedge clk); bus.mem_done = 1'b0;
      chk("store_flush_enable", 32'(bus.lsb_enable), 1);
      chk("store_flush_rdata", bus.lsb_rdata, 32'h11);
      bus.lsb_valid = 1'b0;
      @(negedge clk);
      chk("store_flush_single_pulse", 32'(bus.lsb_enable), 0);

      // rdy low for 5 cycles with MemCtrl holding its done pulse.
      @(negedge clk);
      bus.ic_valid = 1; bus.ic_addr = 32'h800;
      wait_grant("freeze", 32'h800);
      @(negedge clk);
      rdy = 1'b0; bus.mem_done = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("freeze_valid", 32'(bus.mem_valid), 1);
         chk("freeze_addr", bus.mem_addr, 32'h800);
         chk("freeze_no_enable", 32'(bus.ic_enable), 0);
      end
      rdy = 1'b1;
      @(negedge clk); bus.mem_done = 1'b0;
      chk("freeze_enable", 32'(bus.ic_enable), 1);
      chk("freeze_inst", bus.ic_inst, 32'hCAFEF00D);
      chk("freeze_released", 32'(bus.mem_valid), 0);
      bus.ic_valid = 1'b0;
      @(negedge clk);
      chk("freeze_single_pulse", 32'(bus.ic_enable), 0);

      // Asynchronous reset in BUSY.
      @(negedge clk);
      bus.ic_valid = 1; bus.ic_addr = 32'h900;
      wait_grant("rst_busy", 32'h900);
      @(posedge clk);
      #2 rst = 1'b0;
      #1 chk_zero("rst_busy");
      bus.ic_valid = 1'b0;
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      chk("rst_forgotten", 32'(bus.mem_valid), 0);
      rd_next = 32'h0A0A0000;
      gq.push_back('{W_PF, 32'hA00, 3'd4, 1'b0, 32'h0});
      bus.pf_valid = 1; bus.pf_addr = 32'hA00;
      serve(1, 50);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
